// File: rtl/coherence_snoop_engine_pkg.sv
// Shared definitions for the snoop-side coherence engine.
//   states   : stored line-state encoding (reused by the tag array)
//   commands : snooped bus command encoding (reused by the bus interface)
//   coherence_snoop_engine_pkg : protocol modes, FSM states and the
//                                per-mode state legality check.
package states;
   typedef enum logic [2:0] {
      INVALID   = 3'd0,
      SHARED    = 3'd1,
      EXCLUSIVE = 3'd2,
      OWNED     = 3'd3,
      MODIFIED  = 3'd4,
      FORWARD   = 3'd5
   } State;
endpackage

package commands;
   typedef enum logic [1:0] {
      NONE               = 2'd0,
      BUS_READ           = 2'd1,
      BUS_READ_EXCLUSIVE = 2'd2,
      BUS_INVALIDATE     = 2'd3
   } Command;
endpackage

package coherence_snoop_engine_pkg;
   typedef enum logic [1:0] {
      MODE_MSI    = 2'd0,
      MODE_MESI   = 2'd1,
      MODE_MOESI  = 2'd2,
      MODE_MOESIF = 2'd3
   } protocol_mode_e;

   typedef enum logic [2:0] {
      FSM_IDLE   = 3'd0,
      FSM_LOOKUP = 3'd1,
      FSM_DECIDE = 3'd2,
      FSM_SUPPLY = 3'd3,
      FSM_UPDATE = 3'd4
   } fsm_state_e;

   // A state is legal only if the active protocol actually defines it;
   // unused encodings are never legal.
   function automatic logic is_legal(states::State state, protocol_mode_e mode);
      logic ok;
      case (state)
         states::INVALID,
         states::SHARED,
         states::MODIFIED:  ok = 1'b1;
         states::EXCLUSIVE: ok = (mode != MODE_MSI);
         states::OWNED:     ok = (mode == MODE_MOESI) || (mode == MODE_MOESIF);
         states::FORWARD:   ok = (mode == MODE_MOESIF);
         default:           ok = 1'b0;
      endcase
      return ok;
   endfunction
endpackage

// File: rtl/coherence_snoop_next_state.sv
// Combinational snoop-side next-state logic.
// Ports:
//   mode      in  2  protocol mode (protocol_mode_e encoding)
//   command   in  2  snooped bus command
//   state     in  3  current line state (INVALID for a miss)
//   nextState out 3  state the line takes after the snoop
//   supply    out 1  this cache must supply the line data
//   writeBack out 1  memory must capture the supplied data
//   illegal   out 1  state is not defined in this protocol mode
module coherence_snoop_next_state
   import coherence_snoop_engine_pkg::*;
(
   input  logic [1:0] mode,
   input  logic [1:0] command,
   input  logic [2:0] state,
   output logic [2:0] nextState,
   output logic       supply,
   output logic       writeBack,
   output logic       illegal
);

   protocol_mode_e   mode_e;
   commands::Command cmd_e;
   states::State     raw_state;
   states::State     eff_state;
   states::State     nxt;

   assign mode_e    = protocol_mode_e'(mode);
   assign cmd_e     = commands::Command'(command);
   assign raw_state = states::State'(state);

   always_comb begin
      illegal   = !is_legal(raw_state, mode_e);
      // An illegal stored state is handled as if the line were absent.
      eff_state = illegal ? states::INVALID : raw_state;
      nxt       = eff_state;
      supply    = 1'b0;
      writeBack = 1'b0;

      case (cmd_e)
         commands::BUS_INVALIDATE,
         commands::BUS_READ_EXCLUSIVE: nxt = states::INVALID;
         commands::BUS_READ: begin
            case (eff_state)
               states::MODIFIED:  nxt = (mode_e == MODE_MOESI || mode_e == MODE_MOESIF)
                                        ? states::OWNED : states::SHARED;
               states::EXCLUSIVE,
               states::FORWARD:   nxt = states::SHARED;
               default:           nxt = eff_state;
            endcase
         end
         default: nxt = eff_state;
      endcase

      if ((cmd_e == commands::BUS_READ) || (cmd_e == commands::BUS_READ_EXCLUSIVE)) begin
         supply = (eff_state == states::MODIFIED) || (eff_state == states::OWNED) ||
                  (eff_state == states::EXCLUSIVE) || (eff_state == states::FORWARD);
      end

      // Without an OWNED state, dirty data leaving an M line must reach memory.
      writeBack = supply && (eff_state == states::MODIFIED) &&
                  (mode_e == MODE_MSI || mode_e == MODE_MESI);

      nextState = nxt;
   end

endmodule

// File: rtl/coherence_snoop_engine.sv
// Registered snoop-side coherence controller for one snoopy cache.
// Accepts one bus command at a time, looks the line up in the tag array,
// computes the new state for the configured protocol, runs the data-supply
// handshake (with timeout) and writes the new state back.
// Ports:
//   clock, reset            clock; synchronous active-low reset
//   snoopValid/snoopReady   command handshake (ready only when idle)
//   snoopCommand, snoopTag  command and snooped line
//   lookupTag               tag-array read address (driven in LOOKUP)
//   lookupHit, lookupState  tag-array response, sampled one cycle later
//   cpuBusy, cpuBusyTag     CPU-side transaction in flight on that line
//   sharedOut, ownedOut     snoop response lines
//   supplyRequest           this cache supplies the data
//   supplyWriteBack         memory captures the supplied data too
//   supplyDone              bus completed the transfer
//   updateEnable/Tag/State  one-cycle state write-back
//   snoopDone               one-cycle completion pulse
//   illegalState            sticky: stored state illegal for PROTOCOL
//   timeoutError            sticky: supply did not complete in time
module coherence_snoop_engine
   import coherence_snoop_engine_pkg::*;
#(
   parameter int PROTOCOL       = 3,
   parameter int TAG_WIDTH      = 16,
   parameter int STATE_WIDTH    = 3,
   parameter int SUPPLY_TIMEOUT = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   snoopValid,
   output logic                   snoopReady,
   input  logic [1:0]             snoopCommand,
   input  logic [TAG_WIDTH-1:0]   snoopTag,
   output logic [TAG_WIDTH-1:0]   lookupTag,
   input  logic                   lookupHit,
   input  logic [STATE_WIDTH-1:0] lookupState,
   input  logic                   cpuBusy,
   input  logic [TAG_WIDTH-1:0]   cpuBusyTag,
   output logic                   sharedOut,
   output logic                   ownedOut,
   output logic                   supplyRequest,
   output logic                   supplyWriteBack,
   input  logic                   supplyDone,
   output logic                   updateEnable,
   output logic [TAG_WIDTH-1:0]   updateTag,
   output logic [STATE_WIDTH-1:0] updateState,
   output logic                   snoopDone,
   output logic                   illegalState,
   output logic                   timeoutError
);

   localparam int         CNT_W = $clog2(SUPPLY_TIMEOUT) + 1;
   localparam logic [1:0] MODE  = 2'(PROTOCOL);

   fsm_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic                 do_update_q;
   logic                 shared_q, owned_q;
   logic                 illegal_q, timeout_q;

   logic [TAG_WIDTH-1:0] tag_q;
   logic [1:0]           cmd_q;
   logic [2:0]           next_q;
   logic                 wb_q;

   logic [2:0]           looked_state;
   logic [2:0]           ns_next;
   logic                 ns_supply, ns_wb, ns_illegal;
   logic                 conflict;
   logic                 cnt_expired;

   // A miss is presented to the next-state logic as INVALID.
   assign looked_state = lookupHit ? 3'(lookupState) : 3'(states::INVALID);
   assign conflict     = cpuBusy && (cpuBusyTag == tag_q);
   assign cnt_expired  = (cnt_q == CNT_W'(SUPPLY_TIMEOUT - 1));

   coherence_snoop_next_state u_next_state (
      .mode      (MODE),
      .command   (cmd_q),
      .state     (looked_state),
      .nextState (ns_next),
      .supply    (ns_supply),
      .writeBack (ns_wb),
      .illegal   (ns_illegal)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         FSM_IDLE: begin
            if (snoopValid) begin
               // NONE needs neither lookup nor update: go straight to completion.
               state_d = (snoopCommand == 2'(commands::NONE)) ? FSM_UPDATE : FSM_LOOKUP;
            end
         end
         FSM_LOOKUP: if (!conflict) state_d = FSM_DECIDE;
         FSM_DECIDE: state_d = ns_supply ? FSM_SUPPLY : FSM_UPDATE;
         FSM_SUPPLY: if (supplyDone || cnt_expired) state_d = FSM_UPDATE;
         FSM_UPDATE: state_d = FSM_IDLE;
         default:    state_d = FSM_IDLE;
      endcase
   end

   // Control state: FSM, supply counter, response flags and sticky errors.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= FSM_IDLE;
         cnt_q       <= '0;
         do_update_q <= 1'b0;
         shared_q    <= 1'b0;
         owned_q     <= 1'b0;
         illegal_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            FSM_IDLE: begin
               if (snoopValid) begin
                  do_update_q <= 1'b0;
                  shared_q    <= 1'b0;
                  owned_q     <= 1'b0;
               end
            end
            FSM_DECIDE: begin
               do_update_q <= lookupHit && !ns_illegal;
               shared_q    <= lookupHit && !ns_illegal && (looked_state != 3'(states::INVALID));
               owned_q     <= lookupHit && !ns_illegal && (looked_state == 3'(states::OWNED));
               cnt_q       <= '0;
               if (ns_illegal) illegal_q <= 1'b1;
            end
            FSM_SUPPLY: begin
               cnt_q <= cnt_q + 1'b1;
               // supplyDone in the final cycle still counts as a completed supply.
               if (cnt_expired && !supplyDone) timeout_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Transaction data: only meaningful while the FSM is away from IDLE.
   always_ff @(posedge clock) begin
      if (state_q == FSM_IDLE && snoopValid) begin
         tag_q <= snoopTag;
         cmd_q <= snoopCommand;
      end
      if (state_q == FSM_DECIDE) begin
         next_q <= ns_next;
         wb_q   <= ns_wb;
      end
   end

   assign snoopReady      = (state_q == FSM_IDLE);
   assign lookupTag       = (state_q == FSM_LOOKUP) ? tag_q : '0;
   assign sharedOut       = shared_q;
   assign ownedOut        = owned_q;
   assign supplyRequest   = (state_q == FSM_SUPPLY);
   assign supplyWriteBack = (state_q == FSM_SUPPLY) && wb_q;
   assign updateEnable    = (state_q == FSM_UPDATE) && do_update_q;
   assign updateTag       = updateEnable ? tag_q : '0;
   assign updateState     = updateEnable ? STATE_WIDTH'(next_q) : '0;
   assign snoopDone       = (state_q == FSM_UPDATE);
   assign illegalState    = illegal_q;
   assign timeoutError    = timeout_q;

endmodule

// File: tb/tb_coherence_snoop_engine.sv
// Directed bench for coherence_snoop_engine: instance a runs MOESIF,
// instance b runs MSI; both share the same stimulus.
module tb_coherence_snoop_engine;
   localparam int TW = 16;
   localparam logic [2:0] S_I = 3'd0, S_S = 3'd1, S_O = 3'd3, S_M = 3'd4, S_F = 3'd5;
   localparam logic [1:0] C_NONE = 2'd0, C_RD = 2'd1, C_RDX = 2'd2;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          snoopValid = 1'b0;
   logic [1:0]    snoopCommand = 2'd0;
   logic [TW-1:0] snoopTag = '0;
   logic          lookupHit = 1'b0;
   logic [2:0]    lookupState = 3'd0;
   logic          cpuBusy = 1'b0;
   logic [TW-1:0] cpuBusyTag = '0;
   logic          supplyDone = 1'b0;

   logic a_snoopReady, a_sharedOut, a_ownedOut, a_supplyRequest, a_supplyWriteBack;
   logic a_updateEnable, a_snoopDone, a_illegalState, a_timeoutError;
   logic [TW-1:0] a_lookupTag, a_updateTag;
   logic [2:0]    a_updateState;
   logic b_snoopReady, b_sharedOut, b_ownedOut, b_supplyRequest, b_supplyWriteBack;
   logic b_updateEnable, b_snoopDone, b_illegalState, b_timeoutError;
   logic [TW-1:0] b_lookupTag, b_updateTag;
   logic [2:0]    b_updateState;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   coherence_snoop_engine #(.PROTOCOL(3), .TAG_WIDTH(TW), .STATE_WIDTH(3), .SUPPLY_TIMEOUT(64)) u_a (
      .clock(clock), .reset(reset), .snoopValid(snoopValid), .snoopReady(a_snoopReady),
      .snoopCommand(snoopCommand), .snoopTag(snoopTag), .lookupTag(a_lookupTag),
      .lookupHit(lookupHit), .lookupState(lookupState), .cpuBusy(cpuBusy), .cpuBusyTag(cpuBusyTag),
      .sharedOut(a_sharedOut), .ownedOut(a_ownedOut), .supplyRequest(a_supplyRequest),
      .supplyWriteBack(a_supplyWriteBack), .supplyDone(supplyDone), .updateEnable(a_updateEnable),
      .updateTag(a_updateTag), .updateState(a_updateState), .snoopDone(a_snoopDone),
      .illegalState(a_illegalState), .timeoutError(a_timeoutError));

   coherence_snoop_engine #(.PROTOCOL(0), .TAG_WIDTH(TW), .STATE_WIDTH(3), .SUPPLY_TIMEOUT(64)) u_b (
      .clock(clock), .reset(reset), .snoopValid(snoopValid), .snoopReady(b_snoopReady),
      .snoopCommand(snoopCommand), .snoopTag(snoopTag), .lookupTag(b_lookupTag),
      .lookupHit(lookupHit), .lookupState(lookupState), .cpuBusy(cpuBusy), .cpuBusyTag(cpuBusyTag),
      .sharedOut(b_sharedOut), .ownedOut(b_ownedOut), .supplyRequest(b_supplyRequest),
      .supplyWriteBack(b_supplyWriteBack), .supplyDone(supplyDone), .updateEnable(b_updateEnable),
      .updateTag(b_updateTag), .updateState(b_updateState), .snoopDone(b_snoopDone),
      .illegalState(b_illegalState), .timeoutError(b_timeoutError));

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog act=cycle_limit_reached exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   // Cycle 0 presents the command; returns in cycle 1 (first LOOKUP cycle).
   task automatic start(input logic [1:0] cmd, input logic [TW-1:0] tag);
      tick();
      cyc = 0;
      snoopValid = 1'b1; snoopCommand = cmd; snoopTag = tag;
      tick();
      snoopValid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick(); tick();
      tests++; if (a_snoopReady !== 1'b1) begin fails++; $display("FAIL rst_ready act=%0b exp=1", a_snoopReady); end
      tests++; if (a_snoopDone !== 1'b0) begin fails++; $display("FAIL rst_done act=%0b exp=0", a_snoopDone); end
      tests++; if (a_supplyRequest !== 1'b0) begin fails++; $display("FAIL rst_supply act=%0b exp=0", a_supplyRequest); end
      tests++; if (a_lookupTag !== 16'h0) begin fails++; $display("FAIL rst_ltag act=%h exp=0", a_lookupTag); end
      tests++; if (a_illegalState !== 1'b0 || b_timeoutError !== 1'b0) begin fails++; $display("FAIL rst_sticky act=%0b%0b exp=00", a_illegalState, b_timeoutError); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_moesif_read();
      lookupHit = 1'b1; lookupState = S_M;
      start(C_RD, 16'h1234);
      tests++; if (a_lookupTag !== 16'h1234) begin fails++; $display("FAIL t1_ltag act=%h exp=1234", a_lookupTag); end
      tests++; if (a_snoopReady !== 1'b0) begin fails++; $display("FAIL t1_busy act=%0b exp=0", a_snoopReady); end
      tick(); tick();
      tests++; if (a_supplyRequest !== 1'b1) begin fails++; $display("FAIL t1_req3 act=%0b exp=1", a_supplyRequest); end
      tests++; if (a_supplyWriteBack !== 1'b0) begin fails++; $display("FAIL t1_wb act=%0b exp=0", a_supplyWriteBack); end
      tests++; if (a_sharedOut !== 1'b1 || a_ownedOut !== 1'b0) begin fails++; $display("FAIL t1_resp act=%0b%0b exp=10", a_sharedOut, a_ownedOut); end
      tick();
      tests++; if (a_supplyRequest !== 1'b1) begin fails++; $display("FAIL t1_req4 act=%0b exp=1", a_supplyRequest); end
      supplyDone = 1'b1;
      tick();
      supplyDone = 1'b0;
      tests++; if (a_snoopDone !== 1'b1) begin fails++; $display("FAIL t1_done5 act=%0b exp=1", a_snoopDone); end
      tests++; if (a_supplyRequest !== 1'b0) begin fails++; $display("FAIL t1_req5 act=%0b exp=0", a_supplyRequest); end
      tests++; if (a_updateEnable !== 1'b1 || a_updateState !== S_O) begin fails++; $display("FAIL t1_upd act=%0b/%0d exp=1/3", a_updateEnable, a_updateState); end
      tests++; if (a_updateTag !== 16'h1234) begin fails++; $display("FAIL t1_utag act=%h exp=1234", a_updateTag); end
      tick();
      tests++; if (a_snoopReady !== 1'b1 || a_snoopDone !== 1'b0) begin fails++; $display("FAIL t1_idle act=%0b%0b exp=10", a_snoopReady, a_snoopDone); end
   endtask

   task automatic test_msi_read();
      lookupHit = 1'b1; lookupState = S_M;
      start(C_RD, 16'h00A5);
      tick(); tick();
      tests++; if (b_supplyRequest !== 1'b1 || b_supplyWriteBack !== 1'b1) begin fails++; $display("FAIL t2_msi_wb act=%0b%0b exp=11", b_supplyRequest, b_supplyWriteBack); end
      supplyDone = 1'b1;
      tick();
      supplyDone = 1'b0;
      tests++; if (b_snoopDone !== 1'b1 || b_updateEnable !== 1'b1 || b_updateState !== S_S) begin fails++; $display("FAIL t2_msi_upd act=%0b%0b/%0d exp=11/1", b_snoopDone, b_updateEnable, b_updateState); end
      tick();
      lookupState = S_O;
      start(C_RD, 16'h00A6);
      tick();
      tests++; if (b_illegalState !== 1'b0) begin fails++; $display("FAIL t2_ill_early act=%0b exp=0", b_illegalState); end
      tick();
      tests++; if (b_illegalState !== 1'b1) begin fails++; $display("FAIL t2_ill act=%0b exp=1", b_illegalState); end
      tests++; if (b_snoopDone !== 1'b1 || b_updateEnable !== 1'b0 || b_supplyRequest !== 1'b0) begin fails++; $display("FAIL t2_ill_noupd act=%0b%0b%0b exp=100", b_snoopDone, b_updateEnable, b_supplyRequest); end
      tests++; if (a_supplyRequest !== 1'b1 || a_ownedOut !== 1'b1) begin fails++; $display("FAIL t2_o_moesif act=%0b%0b exp=11", a_supplyRequest, a_ownedOut); end
      supplyDone = 1'b1;
      tick();
      supplyDone = 1'b0;
      tests++; if (a_snoopDone !== 1'b1 || a_updateState !== S_O) begin fails++; $display("FAIL t2_o_upd act=%0b/%0d exp=1/3", a_snoopDone, a_updateState); end
      tick();
   endtask

   task automatic test_conflict();
      lookupHit = 1'b1; lookupState = S_S;
      cpuBusy = 1'b1; cpuBusyTag = 16'h0777;
      start(C_RD, 16'h0777);
      for (int c = 2; c <= 5; c++) begin
         tick();
         tests++; if (a_lookupTag !== 16'h0777) begin fails++; $display("FAIL t3_stall c%0d act=%h exp=0777", c, a_lookupTag); end
      end
      tick();
      cpuBusy = 1'b0;
      tests++; if (a_lookupTag !== 16'h0777) begin fails++; $display("FAIL t3_stall6 act=%h exp=0777", a_lookupTag); end
      tick();
      tests++; if (a_snoopDone !== 1'b0) begin fails++; $display("FAIL t3_early act=%0b exp=0", a_snoopDone); end
      tick();
      tests++; if (a_snoopDone !== 1'b1 || a_updateEnable !== 1'b1 || a_updateState !== S_S) begin fails++; $display("FAIL t3_done act=%0b%0b/%0d exp=11/1", a_snoopDone, a_updateEnable, a_updateState); end
      tick();
      cpuBusy = 1'b1; cpuBusyTag = 16'h0778;
      start(C_RD, 16'h0777);
      tick(); tick();
      tests++; if (a_snoopDone !== 1'b1) begin fails++; $display("FAIL t3_nomatch act=%0b exp=1", a_snoopDone); end
      cpuBusy = 1'b0;
      tick();
   endtask

   task automatic test_timeout_boundary();
      lookupHit = 1'b1; lookupState = S_F;
      start(C_RD, 16'h0F0F);
      while (cyc < 66) tick();
      tests++; if (a_supplyRequest !== 1'b1) begin fails++; $display("FAIL t4b_req66 act=%0b exp=1", a_supplyRequest); end
      supplyDone = 1'b1;
      tick();
      supplyDone = 1'b0;
      tests++; if (a_snoopDone !== 1'b1 || a_timeoutError !== 1'b0 || a_updateState !== S_S) begin fails++; $display("FAIL t4b_donewins act=%0b%0b/%0d exp=10/1", a_snoopDone, a_timeoutError, a_updateState); end
      tick();
   endtask

   task automatic test_timeout();
      lookupHit = 1'b1; lookupState = S_F;
      start(C_RD, 16'h0F10);
      while (cyc < 66) tick();
      tests++; if (a_supplyRequest !== 1'b1 || a_timeoutError !== 1'b0) begin fails++; $display("FAIL t4_pre act=%0b%0b exp=10", a_supplyRequest, a_timeoutError); end
      tick();
      tests++; if (a_supplyRequest !== 1'b0 || a_timeoutError !== 1'b1) begin fails++; $display("FAIL t4_to act=%0b%0b exp=01", a_supplyRequest, a_timeoutError); end
      tests++; if (a_snoopDone !== 1'b1 || a_updateEnable !== 1'b1 || a_updateState !== S_S) begin fails++; $display("FAIL t4_upd act=%0b%0b/%0d exp=11/1", a_snoopDone, a_updateEnable, a_updateState); end
      tick();
      tests++; if (a_timeoutError !== 1'b1 || a_snoopReady !== 1'b1) begin fails++; $display("FAIL t4_sticky act=%0b%0b exp=11", a_timeoutError, a_snoopReady); end
   endtask

   task automatic test_miss();
      lookupHit = 1'b0; lookupState = S_M;
      start(C_RDX, 16'h0042);
      tick(); tick();
      tests++; if (a_snoopDone !== 1'b1 || a_updateEnable !== 1'b0) begin fails++; $display("FAIL t5_miss act=%0b%0b exp=10", a_snoopDone, a_updateEnable); end
      tests++; if (a_sharedOut !== 1'b0 || a_supplyRequest !== 1'b0) begin fails++; $display("FAIL t5_resp act=%0b%0b exp=00", a_sharedOut, a_supplyRequest); end
      tick();
      lookupHit = 1'b1;
   endtask

   task automatic test_none();
      lookupHit = 1'b1; lookupState = S_M;
      start(C_NONE, 16'h0099);
      tests++; if (a_snoopDone !== 1'b1 || a_updateEnable !== 1'b0 || a_lookupTag !== 16'h0) begin fails++; $display("FAIL t_none act=%0b%0b/%h exp=10/0000", a_snoopDone, a_updateEnable, a_lookupTag); end
      tick();
      tests++; if (a_snoopReady !== 1'b1) begin fails++; $display("FAIL t_none_idle act=%0b exp=1", a_snoopReady); end
   endtask

   task automatic test_back_to_back();
      tick();
      snoopValid = 1'b1; snoopCommand = C_NONE; snoopTag = 16'h0001;
      tick();
      tests++; if (a_snoopDone !== 1'b1 || a_snoopReady !== 1'b0) begin fails++; $display("FAIL b2b_first act=%0b%0b exp=10", a_snoopDone, a_snoopReady); end
      tick();
      tests++; if (a_snoopReady !== 1'b1 || a_snoopDone !== 1'b0) begin fails++; $display("FAIL b2b_wait act=%0b%0b exp=10", a_snoopReady, a_snoopDone); end
      tick();
      snoopValid = 1'b0;
      tests++; if (a_snoopDone !== 1'b1) begin fails++; $display("FAIL b2b_second act=%0b exp=1", a_snoopDone); end
      tick();
   endtask

   task automatic test_reset_mid();
      lookupHit = 1'b1; lookupState = S_M;
      start(C_RD, 16'h0123);
      tick(); tick();
      tests++; if (a_supplyRequest !== 1'b1) begin fails++; $display("FAIL t6_insupply act=%0b exp=1", a_supplyRequest); end
      reset = 1'b0;
      tick();
      tests++; if (a_supplyRequest !== 1'b0 || a_snoopReady !== 1'b1 || a_sharedOut !== 1'b0) begin fails++; $display("FAIL t6_outs act=%0b%0b%0b exp=010", a_supplyRequest, a_snoopReady, a_sharedOut); end
      tests++; if (a_timeoutError !== 1'b0 || b_illegalState !== 1'b0) begin fails++; $display("FAIL t6_sticky act=%0b%0b exp=00", a_timeoutError, b_illegalState); end
      tests++; if (a_updateEnable !== 1'b0 || a_snoopDone !== 1'b0) begin fails++; $display("FAIL t6_abort act=%0b%0b exp=00", a_updateEnable, a_snoopDone); end
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         tests++; if (a_snoopDone !== 1'b0 || a_updateEnable !== 1'b0 || a_snoopReady !== 1'b1) begin fails++; $display("FAIL t6_silent c%0d act=%0b%0b%0b exp=001", c, a_snoopDone, a_updateEnable, a_snoopReady); end
      end
   endtask

   initial begin
      test_reset();
      test_moesif_read();
      test_msi_read();
      test_conflict();
      test_timeout_boundary();
      test_timeout();
      test_miss();
      test_none();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
